// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Issues word-aligned requests to an in-order
// instruction memory with a req/gnt handshake. Responses are buffered in a
// 2-entry FIFO that presents instructions to decode.
//
// The number of requests in flight plus the entries buffered never exceeds
// two, so the FIFO cannot overflow.
//
// A redirect flushes the FIFO and loads a new fetch pc. Responses still in
// flight at that point belong to the old stream. The DRAIN state swallows
// them before fetching resumes.
//
// Optional feature (compile-time macro):
//   FETCH_PERF_CNT_EN  adds perf_fetch_cnt_o, a wrapping 32-bit count of
//                      instructions handed to decode (FIFO pops).
//
// Parameters:
//   RESET_PC        first fetch address after reset (word-aligned)
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   imem_req_o      fetch request, held with imem_addr_o until granted
//   imem_addr_o     fetch address, bits [1:0] always zero
//   imem_gnt_i      request accepted this cycle
//   imem_rvalid_i   response valid (in order)
//   imem_rdata_i    response instruction word
//   redirect_i      taken branch / jump redirect
//   redirect_pc_i   redirect target, bits [1:0] ignored
//   id_ready_i      decode accepts the head instruction
//   if_valid_o      head instruction valid
//   if_instr_o      head instruction word
//   if_pc_o         head instruction pc
//   if_pc_plus4_o   head instruction pc + 4
//   perf_fetch_cnt_o  (FETCH_PERF_CNT_EN only) delivered-instruction count
//------------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_o
`endif
);

    localparam logic [31:0] BOOT_PC = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Control state
    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_outstanding;   // granted requests awaiting a response, 0..2

    // FIFO of {pc, instr}
    logic [31:0] r_fifo_pc    [0:1];
    logic [31:0] r_fifo_instr [0:1];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    // Combinational control
    logic        w_pop;
    logic [2:0]  w_in_use;
    logic        w_req;
    logic        w_grant;
    logic        w_rsp;
    logic        w_push;
    logic [31:0] w_rsp_pc;
    logic [31:0] w_redirect_pc;
    logic [1:0]  w_out_next;
    logic [1:0]  w_count_next;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path. Missing
        // one would infer a latch.
        w_pop         = 1'b0;
        w_in_use      = 3'd0;
        w_req         = 1'b0;
        w_grant       = 1'b0;
        w_rsp         = 1'b0;
        w_push        = 1'b0;
        w_rsp_pc      = 32'd0;
        w_redirect_pc = 32'd0;
        w_out_next    = 2'd0;
        w_count_next  = 2'd0;

        w_pop = (r_count != 2'd0) && id_ready_i;

        // A pop this cycle frees its slot in time for the new request's
        // response. Counting it keeps one instruction per cycle with
        // single-cycle memory. The pop really happens, so next cycle's
        // occupancy is lower too. An ungranted request therefore never
        // drops because id_ready_i moved.
        w_in_use = {1'b0, r_outstanding} + {1'b0, r_count} - {2'b00, w_pop};

        w_req   = (r_state == ST_RUN) && !redirect_i && (w_in_use < 3'd2);
        w_grant = w_req && imem_gnt_i;

        // A response with nothing outstanding is a protocol error. It is
        // ignored entirely.
        w_rsp  = imem_rvalid_i && (r_outstanding != 2'd0);
        w_push = w_rsp && (r_state == ST_RUN) && !redirect_i;

        // In RUN, the outstanding requests are the ones just before
        // r_fetch_pc, in order. The oldest (this response) is therefore
        // outstanding*4 bytes back.
        w_rsp_pc = r_fetch_pc - {28'd0, r_outstanding, 2'b00};

        w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

        w_out_next = r_outstanding + {1'b0, w_grant} - {1'b0, w_rsp};

        if (redirect_i) begin
            w_count_next = 2'd0;
        end else begin
            w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Control FSM, fetch pc and outstanding counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from pre-edge values.
        if (!rst_ni) begin
            r_state       <= ST_BOOT;
            r_fetch_pc    <= BOOT_PC;
            r_outstanding <= 2'd0;
        end else begin
            r_outstanding <= w_out_next;
            case (r_state)
                // One idle cycle after reset release. A redirect here has
                // no stream to cancel and is ignored.
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    if (redirect_i) begin
                        r_fetch_pc <= w_redirect_pc;
                        r_state    <= (w_out_next != 2'd0) ? ST_DRAIN : ST_RUN;
                    end else if (r_state == ST_RUN) begin
                        if (w_grant) begin
                            r_fetch_pc <= r_fetch_pc + 32'd4;  // wraps at 2^32
                        end
                    end else if (w_out_next == 2'd0) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy. A redirect flushes, with priority over
    // a pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_count <= w_count_next;
            if (redirect_i) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        // NOTE: the data array is not reset. Outputs are forced to zero
        // while the FIFO is empty, so stale or uninitialised entries are
        // never visible.
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= w_rsp_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;

    assign if_valid_o    = (r_count != 2'd0);
    assign if_instr_o    = if_valid_o ? r_fifo_instr[r_rd_ptr] : 32'd0;
    assign if_pc_o       = if_valid_o ? r_fifo_pc[r_rd_ptr]    : 32'd0;
    assign if_pc_plus4_o = if_valid_o ? (r_fifo_pc[r_rd_ptr] + 32'd4) : 32'd0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_cnt <= 32'd0;
        end else if (w_pop) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt_o = r_perf_cnt;
`endif

endmodule
